// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel classifier.
// Holds the geometry and pink-threshold defaults, the frame-tracking FSM
// encoding and the per-class flag byte values.
package pixel_pkg;

    localparam int unsigned MaxColsDefault  = 640;
    localparam int unsigned MaxRowsDefault  = 480;
    localparam int unsigned PinkRMinDefault = 24;
    localparam int unsigned PinkGMaxDefault = 20;
    localparam int unsigned PinkBMinDefault = 12;

    localparam logic [7:0] ClassOn  = 8'hFF;
    localparam logic [7:0] ClassOff = 8'h00;

    typedef enum logic [1:0] {
        StIdle,
        StVsync,
        StFrame
    } state_e;

endpackage

// File: rtl/rgb565_classify.sv
// Combinational RGB565 pixel classifier.
// Ports:
//   r_i, g_i, b_i : 5/6/5-bit colour components of one pixel
//   valid_o       : {white flags, pink flags}, each byte ClassOn or ClassOff
//   pink_o        : single-bit pink match, used for frame counting
module rgb565_classify
    import pixel_pkg::*;
#(
    parameter int unsigned PINK_R_MIN = PinkRMinDefault,
    parameter int unsigned PINK_G_MAX = PinkGMaxDefault,
    parameter int unsigned PINK_B_MIN = PinkBMinDefault
) (
    input  logic [4:0]  r_i,
    input  logic [5:0]  g_i,
    input  logic [4:0]  b_i,
    output logic [15:0] valid_o,
    output logic        pink_o
);

    localparam logic [4:0] RMin = 5'(PINK_R_MIN);
    localparam logic [5:0] GMax = 6'(PINK_G_MAX);
    localparam logic [4:0] BMin = 5'(PINK_B_MIN);

    logic white;

    assign pink_o  = (r_i >= RMin) && (g_i <= GMax) && (b_i >= BMin);
    assign white   = (r_i == 5'h1F) && (g_i == 6'h3F) && (b_i == 5'h1F);
    assign valid_o = {white ? ClassOn : ClassOff, pink_o ? ClassOn : ClassOff};

endmodule

// File: rtl/pixel_classifier.sv
// Camera-stream pixel classifier.
// Registers the camera bus, tracks frames with an IDLE/VSYNC/FRAME FSM,
// assembles RGB565 pixels from byte pairs, classifies them and counts pink
// pixels per frame.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   cam_data/href/vsync   : camera byte bus (high byte first), line and frame syncs
//   x_row, y_col, valid   : row, column and class flags of the strobed pixel
//   pix_strobe            : one-cycle pixel qualifier, 2 clk after the second byte
//   frame_done            : one-cycle end-of-frame pulse
//   match_count           : pink total of the last completed frame
//   err_flags             : sticky {overflow, odd_byte, early_vsync}
module pixel_classifier
    import pixel_pkg::*;
#(
    parameter int unsigned MAX_COLS   = MaxColsDefault,
    parameter int unsigned MAX_ROWS   = MaxRowsDefault,
    parameter int unsigned PINK_R_MIN = PinkRMinDefault,
    parameter int unsigned PINK_G_MAX = PinkGMaxDefault,
    parameter int unsigned PINK_B_MIN = PinkBMinDefault
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  cam_data,
    input  logic        cam_href,
    input  logic        cam_vsync,
    output logic [15:0] x_row,
    output logic [15:0] y_col,
    output logic [15:0] valid,
    output logic        pix_strobe,
    output logic        frame_done,
    output logic [31:0] match_count,
    output logic [2:0]  err_flags
);

    localparam logic [15:0] MaxCols = 16'(MAX_COLS);
    localparam logic [15:0] MaxRows = 16'(MAX_ROWS);

    // Registered camera inputs
    logic [7:0] data_q;
    logic       href_q, vsync_q, href_prev_q;

    state_e state_q, state_d;

    logic        phase_q, line_pix_q;
    logic [7:0]  byte0_q;
    logic [15:0] col_q, row_q;

    // Assembled-pixel stage
    logic        p_valid_q;
    logic [4:0]  p_r_q, p_b_q;
    logic [5:0]  p_g_q;
    logic [15:0] p_col_q, p_row_q;

    // Output stage
    logic [15:0] x_row_q, y_col_q, valid_q;
    logic        strobe_q, frame_done_q;
    logic [31:0] match_count_q, acc_q, acc_sum;
    logic [2:0]  err_q;

    logic [15:0] cls_valid;
    logic        cls_pink;

    logic in_frame, enter_frame, frame_end, accept, pix_done, href_fall, in_range;

    // In FRAME vsync_q has been low since entry, so any high sample is a rising edge.
    assign in_frame    = (state_q == StFrame);
    assign enter_frame = (state_q == StVsync) && !vsync_q;
    assign frame_end   = in_frame && vsync_q;
    assign accept      = in_frame && href_q && !vsync_q;
    assign pix_done    = accept && phase_q;
    assign href_fall   = in_frame && !vsync_q && href_prev_q && !href_q;
    assign in_range    = (col_q < MaxCols) && (row_q < MaxRows);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (vsync_q)  state_d = StVsync;
            StVsync: if (!vsync_q) state_d = StFrame;
            StFrame: if (vsync_q)  state_d = StVsync;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    rgb565_classify #(
        .PINK_R_MIN (PINK_R_MIN),
        .PINK_G_MAX (PINK_G_MAX),
        .PINK_B_MIN (PINK_B_MIN)
    ) u_classify (
        .r_i     (p_r_q),
        .g_i     (p_g_q),
        .b_i     (p_b_q),
        .valid_o (cls_valid),
        .pink_o  (cls_pink)
    );

    // A pixel leaving the assembly stage in the frame_end cycle still counts
    // toward the ending frame.
    always_comb begin
        acc_sum = acc_q;
        if (p_valid_q && cls_pink && (acc_q != 32'hFFFF_FFFF)) acc_sum = acc_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q        <= '0;
            href_q        <= 1'b0;
            vsync_q       <= 1'b0;
            href_prev_q   <= 1'b0;
            phase_q       <= 1'b0;
            line_pix_q    <= 1'b0;
            byte0_q       <= '0;
            col_q         <= '0;
            row_q         <= '0;
            p_valid_q     <= 1'b0;
            p_r_q         <= '0;
            p_g_q         <= '0;
            p_b_q         <= '0;
            p_col_q       <= '0;
            p_row_q       <= '0;
            x_row_q       <= '0;
            y_col_q       <= '0;
            valid_q       <= '0;
            strobe_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            match_count_q <= '0;
            acc_q         <= '0;
            err_q         <= '0;
        end else begin
            data_q      <= cam_data;
            href_q      <= cam_href;
            vsync_q     <= cam_vsync;
            href_prev_q <= href_q;

            // Phase clears whenever a byte is not accepted, dropping any partial pixel.
            phase_q <= accept ? ~phase_q : 1'b0;
            if (accept && !phase_q) byte0_q <= data_q;

            if (enter_frame || frame_end) begin
                col_q      <= '0;
                row_q      <= '0;
                line_pix_q <= 1'b0;
            end else if (href_fall) begin
                col_q      <= '0;
                line_pix_q <= 1'b0;
                if (line_pix_q && (row_q != 16'hFFFF)) row_q <= row_q + 16'd1;
            end else if (pix_done) begin
                line_pix_q <= 1'b1;
                if (col_q != 16'hFFFF) col_q <= col_q + 16'd1;
            end

            p_valid_q <= pix_done && in_range;
            if (pix_done) begin
                p_r_q   <= byte0_q[7:3];
                p_g_q   <= {byte0_q[2:0], data_q[7:5]};
                p_b_q   <= data_q[4:0];
                p_col_q <= col_q;
                p_row_q <= row_q;
            end

            if (pix_done && !in_range)  err_q[2] <= 1'b1;
            if (href_fall && phase_q)   err_q[1] <= 1'b1;
            if (frame_end && href_q)    err_q[0] <= 1'b1;

            strobe_q <= p_valid_q;
            if (p_valid_q) begin
                x_row_q <= p_row_q;
                y_col_q <= p_col_q;
                valid_q <= cls_valid;
            end

            frame_done_q <= frame_end;
            if (frame_end) begin
                match_count_q <= acc_sum;
                acc_q         <= '0;
            end else begin
                acc_q <= acc_sum;
            end
        end
    end

    assign x_row       = x_row_q;
    assign y_col       = y_col_q;
    assign valid       = valid_q;
    assign pix_strobe  = strobe_q;
    assign frame_done  = frame_done_q;
    assign match_count = match_count_q;
    assign err_flags   = err_q;

endmodule

// File: tb/tb_pixel_classifier.sv
// Self-checking bench for pixel_classifier (MAX_COLS=4, MAX_ROWS=2).
module tb_pixel_classifier;

    localparam int unsigned MC = 4;
    localparam int unsigned MR = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  cam_data = '0;
    logic        cam_href = 1'b0;
    logic        cam_vsync = 1'b0;
    logic [15:0] x_row, y_col, valid;
    logic        pix_strobe, frame_done;
    logic [31:0] match_count;
    logic [2:0]  err_flags;

    pixel_classifier #(
        .MAX_COLS   (MC),
        .MAX_ROWS   (MR),
        .PINK_R_MIN (24),
        .PINK_G_MAX (20),
        .PINK_B_MIN (12)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cam_data    (cam_data),
        .cam_href    (cam_href),
        .cam_vsync   (cam_vsync),
        .x_row       (x_row),
        .y_col       (y_col),
        .valid       (valid),
        .pix_strobe  (pix_strobe),
        .frame_done  (frame_done),
        .match_count (match_count),
        .err_flags   (err_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] row;
        logic [15:0] col;
        logic [15:0] val;
        int unsigned cyc;
    } pix_t;

    pix_t        exp_q[$];
    logic [31:0] frm_q[$];
    int          checks = 0;
    int          failures = 0;
    int          strobes = 0;
    int unsigned cyc = 0;
    int unsigned m_row = 0, m_col = 0, m_pink = 0;
    bit          m_line_pix = 1'b0, m_active = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] cls(input logic [4:0] r, input logic [5:0] g,
                                        input logic [4:0] b);
        logic pink, white;
        pink  = (r >= 5'd24) && (g <= 6'd20) && (b >= 5'd12);
        white = (r == 5'd31) && (g == 6'd63) && (b == 5'd31);
        return {white ? 8'hFF : 8'h00, pink ? 8'hFF : 8'h00};
    endfunction

    // Scoreboard: pop expected pixels and frame totals as the DUT reports them.
    always @(negedge clk) begin
        if (pix_strobe === 1'b1) begin
            pix_t e;
            strobes++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe: got row=%0d col=%0d valid=%h, expected none",
                         x_row, y_col, valid);
            end else begin
                e = exp_q.pop_front();
                if (x_row !== e.row || y_col !== e.col || valid !== e.val || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL pixel: got row=%0d col=%0d valid=%h cyc=%0d, expected row=%0d col=%0d valid=%h cyc=%0d",
                             x_row, y_col, valid, cyc, e.row, e.col, e.val, e.cyc);
                end
            end
        end
        if (frame_done === 1'b1) begin
            logic [31:0] m;
            checks++;
            if (frm_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_frame_done: got match_count=%0d, expected no pulse",
                         match_count);
            end else begin
                m = frm_q.pop_front();
                if (match_count !== m) begin
                    failures++;
                    $display("FAIL match_count: got %0d, expected %0d", match_count, m);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic h, input logic v);
        cam_data  = d;
        cam_href  = h;
        cam_vsync = v;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(8'h00, 1'b0, 1'b0);
        tick();
        reset    = 1'b0;
        m_active = 1'b0;
        m_pink   = 0;
    endtask

    task automatic frame_start();
        repeat (2) drive(8'h00, 1'b0, 1'b1);
        repeat (2) drive(8'h00, 1'b0, 1'b0);
        m_active   = 1'b1;
        m_row      = 0;
        m_col      = 0;
        m_line_pix = 1'b0;
        m_pink     = 0;
    endtask

    task automatic frame_end();
        frm_q.push_back(m_pink);
        m_pink   = 0;
        m_active = 1'b0;
        repeat (3) drive(8'h00, 1'b0, 1'b1);
    endtask

    task automatic send_pixel(input logic [4:0] r, input logic [5:0] g, input logic [4:0] b);
        logic [15:0] v;
        drive({r, g[5:3]}, 1'b1, 1'b0);
        drive({g[2:0], b}, 1'b1, 1'b0);
        v = cls(r, g, b);
        if (m_active && m_col < MC && m_row < MR) begin
            exp_q.push_back('{row: 16'(m_row), col: 16'(m_col), val: v, cyc: cyc + 2});
            if (v[0]) m_pink++;
        end
        m_col++;
        m_line_pix = 1'b1;
    endtask

    task automatic end_line();
        repeat (2) drive(8'h00, 1'b0, 1'b0);
        if (m_line_pix) m_row++;
        m_col      = 0;
        m_line_pix = 1'b0;
    endtask

    task automatic drain_and_check(input logic [2:0] exp_err, input int exp_strobes,
                                   input int strobes0);
        repeat (4) tick();
        checks++;
        if (exp_q.size() != 0 || frm_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got %0d pixels and %0d frames pending, expected 0",
                     exp_q.size(), frm_q.size());
        end
        checks++;
        if (err_flags !== exp_err) begin
            failures++;
            $display("FAIL err_flags: got %b, expected %b", err_flags, exp_err);
        end
        checks++;
        if (strobes - strobes0 != exp_strobes) begin
            failures++;
            $display("FAIL strobe_count: got %0d, expected %0d", strobes - strobes0, exp_strobes);
        end
        exp_q.delete();
        frm_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({x_row, y_col, valid} !== 48'h0 || pix_strobe !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_pixel_outputs: got row=%h col=%h valid=%h strobe=%b done=%b, expected all 0",
                     x_row, y_col, valid, pix_strobe, frame_done);
        end
        checks++;
        if (match_count !== 32'h0 || err_flags !== 3'b000) begin
            failures++;
            $display("FAIL reset_status: got match_count=%h err_flags=%b, expected 0 and 000",
                     match_count, err_flags);
        end
    endtask

    task automatic test_frame_pink();
        int s0;
        do_reset();
        s0 = strobes;
        frame_start();
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < 4; p++) send_pixel(5'd31, 6'd0, 5'd15);
            end_line();
        end
        frame_end();
        drain_and_check(3'b000, 8, s0);
    endtask

    task automatic test_white();
        int s0;
        do_reset();
        s0 = strobes;
        frame_start();
        for (int p = 0; p < 4; p++) send_pixel(5'd31, 6'd63, 5'd31);
        end_line();
        frame_end();
        drain_and_check(3'b000, 4, s0);
    endtask

    task automatic test_thresholds();
        int s0;
        do_reset();
        s0 = strobes;
        frame_start();
        send_pixel(5'd24, 6'd20, 5'd12);
        send_pixel(5'd23, 6'd20, 5'd12);
        send_pixel(5'd24, 6'd21, 5'd12);
        send_pixel(5'd24, 6'd20, 5'd11);
        end_line();
        for (int p = 0; p < 4; p++)
            send_pixel(5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)),
                       5'($urandom_range(0, 31)));
        end_line();
        frame_end();
        drain_and_check(3'b000, 8, s0);
    endtask

    task automatic test_odd_byte();
        int s0;
        do_reset();
        s0 = strobes;
        frame_start();
        send_pixel(5'd30, 6'd5, 5'd20);
        drive(8'hF8, 1'b1, 1'b0);
        end_line();
        frame_end();
        drain_and_check(3'b010, 1, s0);
    endtask

    task automatic test_col_overflow();
        int s0;
        do_reset();
        s0 = strobes;
        frame_start();
        for (int p = 0; p < 5; p++) send_pixel(5'd31, 6'd0, 5'd15);
        end_line();
        frame_end();
        drain_and_check(3'b100, 4, s0);
    endtask

    task automatic test_row_overflow();
        int s0;
        do_reset();
        s0 = strobes;
        frame_start();
        for (int l = 0; l < 3; l++) begin
            send_pixel(5'd25, 6'd1, 5'd13);
            end_line();
        end
        frame_end();
        drain_and_check(3'b100, 2, s0);
    endtask

    // Vsync rises right after the last pixel: its strobe and frame_done coincide.
    task automatic test_early_vsync();
        int s0;
        do_reset();
        s0 = strobes;
        frame_start();
        send_pixel(5'd31, 6'd0, 5'd15);
        send_pixel(5'd31, 6'd0, 5'd15);
        frm_q.push_back(m_pink);
        m_active = 1'b0;
        drive(8'hF8, 1'b1, 1'b1);
        repeat (2) drive(8'h00, 1'b0, 1'b1);
        frame_start();
        send_pixel(5'd31, 6'd0, 5'd15);
        end_line();
        frame_end();
        drain_and_check(3'b001, 3, s0);
    endtask

    // Runs without an initial reset so the mid-frame reset has state to clear.
    task automatic test_reset_midframe();
        int s0;
        s0 = strobes;
        frame_start();
        for (int p = 0; p < 3; p++) send_pixel(5'd31, 6'd0, 5'd15);
        end_line();
        do_reset();
        checks++;
        if ({x_row, y_col, valid} !== 48'h0 || match_count !== 32'h0 || err_flags !== 3'b000
            || pix_strobe !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL midframe_reset_outputs: got row=%h col=%h valid=%h mc=%h err=%b, expected all 0",
                     x_row, y_col, valid, match_count, err_flags);
        end
        for (int p = 0; p < 2; p++) send_pixel(5'd31, 6'd0, 5'd15);
        end_line();
        frame_start();
        send_pixel(5'd31, 6'd0, 5'd15);
        send_pixel(5'd1, 6'd40, 5'd2);
        end_line();
        frame_end();
        drain_and_check(3'b000, 5, s0);
    endtask

    initial begin
        test_reset();
        test_frame_pink();
        test_white();
        test_thresholds();
        test_odd_byte();
        test_col_overflow();
        test_row_overflow();
        test_early_vsync();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
